// File: rtl/alu_result_buffer.sv
// Collects tagged ALU unit results into a first-word-fall-through FIFO with a valid/ready output.
// Optional macro ALU_RESULT_PARITY_EN adds a stored even-parity bit per entry (Parity_OUT).
module alu_result_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Arith_OUT,
  input  logic                  Arith_Flag,
  input  logic [DATA_WIDTH-1:0] Logic_OUT,
  input  logic                  Logic_Flag,
  input  logic [DATA_WIDTH-1:0] CMP_OUT,
  input  logic                  CMP_Flag,
  input  logic [DATA_WIDTH-1:0] Shift_OUT,
  input  logic                  Shift_Flag,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] ALU_OUT,
  output logic [1:0]            Src_Tag,
  output logic                  OUT_VALID,
  output logic [CNT_WIDTH-1:0]  Fifo_Count,
  output logic                  Collision_Err,
  output logic                  Overflow_Err
`ifdef ALU_RESULT_PARITY_EN
  , output logic                Parity_OUT
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  typedef struct packed {
`ifdef ALU_RESULT_PARITY_EN
    logic                  par;
`endif
    logic [1:0]            tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                entry_d, head;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  col_q, ovf_q;
  logic [2:0]            nflags;
  logic                  push_req, collision, full, empty, pop, push, ovf;

  assign nflags    = {2'b0, Arith_Flag} + {2'b0, Logic_Flag} + {2'b0, CMP_Flag} + {2'b0, Shift_Flag};
  assign push_req  = (nflags == 3'd1);
  assign collision = (nflags > 3'd1);
  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign pop       = !empty && OUT_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign ovf       = push_req && full && !pop;

  always_comb begin
    entry_d = '0;
    unique case ({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag})
      4'b1000: begin entry_d.tag = 2'b00; entry_d.data = Arith_OUT; end
      4'b0100: begin entry_d.tag = 2'b01; entry_d.data = Logic_OUT; end
      4'b0010: begin entry_d.tag = 2'b10; entry_d.data = CMP_OUT;   end
      4'b0001: begin entry_d.tag = 2'b11; entry_d.data = Shift_OUT; end
      default: entry_d = '0;
    endcase
`ifdef ALU_RESULT_PARITY_EN
    entry_d.par = ^entry_d.data;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_WIDTH'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      col_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      col_q <= collision;
      ovf_q <= ovf;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  assign head          = mem_q[rd_ptr_q];
  assign ALU_OUT       = empty ? '0 : head.data;
  assign Src_Tag       = empty ? 2'b00 : head.tag;
  assign OUT_VALID     = !empty;
  assign Fifo_Count    = cnt_q;
  assign Collision_Err = col_q;
  assign Overflow_Err  = ovf_q;
`ifdef ALU_RESULT_PARITY_EN
  assign Parity_OUT    = empty ? 1'b0 : head.par;
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: queue-based reference model checked every cycle plus literal checks.
module tb_alu_result_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
  logic          Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
  logic          OUT_READY = 1'b0;
  logic [DW-1:0] ALU_OUT;
  logic [1:0]    Src_Tag;
  logic          OUT_VALID;
  logic [2:0]    Fifo_Count;
  logic          Collision_Err, Overflow_Err;
`ifdef ALU_RESULT_PARITY_EN
  logic          Parity_OUT;
`endif

  alu_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
    .OUT_READY(OUT_READY),
    .ALU_OUT(ALU_OUT), .Src_Tag(Src_Tag), .OUT_VALID(OUT_VALID),
    .Fifo_Count(Fifo_Count), .Collision_Err(Collision_Err), .Overflow_Err(Overflow_Err)
`ifdef ALU_RESULT_PARITY_EN
    , .Parity_OUT(Parity_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit seen_ffff = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {tag,data}, updated at each edge from the sampled inputs.
  typedef struct { logic [1:0] tag; logic [DW-1:0] data; } ent_t;
  ent_t q[$];
  bit   exp_col = 0, exp_ovf = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      exp_col = 0;
      exp_ovf = 0;
    end else begin
      int  nf;
      bit  do_pop;
      ent_t e;
      nf = $countones({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag});
      do_pop  = (q.size() > 0) && OUT_READY;
      exp_col = (nf > 1);
      exp_ovf = (nf == 1) && (q.size() == DEPTH) && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (nf == 1 && !exp_ovf) begin
        if (Arith_Flag)      begin e.tag = 2'd0; e.data = Arith_OUT; end
        else if (Logic_Flag) begin e.tag = 2'd1; e.data = Logic_OUT; end
        else if (CMP_Flag)   begin e.tag = 2'd2; e.data = CMP_OUT;   end
        else                 begin e.tag = 2'd3; e.data = Shift_OUT; end
        q.push_back(e);
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      logic [DW-1:0] ed;
      logic [1:0]    et;
      ed = (q.size() > 0) ? q[0].data : '0;
      et = (q.size() > 0) ? q[0].tag  : 2'b00;
      chk("m_data",  32'(ALU_OUT),      32'(ed));
      chk("m_tag",   32'(Src_Tag),      32'(et));
      chk("m_valid", 32'(OUT_VALID),    32'(q.size() > 0));
      chk("m_count", 32'(Fifo_Count),   32'(q.size()));
      chk("m_col",   32'(Collision_Err), 32'(exp_col));
      chk("m_ovf",   32'(Overflow_Err), 32'(exp_ovf));
`ifdef ALU_RESULT_PARITY_EN
      chk("m_par",   32'(Parity_OUT),   32'((q.size() > 0) ? ^q[0].data : 1'b0));
`endif
      if (OUT_VALID && ALU_OUT == 16'hFFFF) seen_ffff = 1'b1;
    end
  end

  // One clock: drive flags/data/ready just after an edge, then wait for the next edge.
  task automatic step(input logic [3:0] flags, input logic [DW-1:0] d, input logic rdy);
    Arith_OUT  = flags[3] ? d : DW'($urandom);
    Logic_OUT  = flags[2] ? d : DW'($urandom);
    CMP_OUT    = flags[1] ? d : DW'($urandom);
    Shift_OUT  = flags[0] ? d : DW'($urandom);
    {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = flags;
    OUT_READY  = rdy;
    @(posedge CLK); #1;
    {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = 4'b0;
    OUT_READY  = 1'b0;
  endtask

  // Wait to the falling edge so literal checks see settled outputs.
  task automatic mid();
    @(negedge CLK); #1;
  endtask

  initial begin
    #12 RST = 1'b0;
    @(posedge CLK); #1;
    mid();
    chk("rst_valid", 32'(OUT_VALID), 0);
    chk("rst_count", 32'(Fifo_Count), 0);
    chk("rst_data",  32'(ALU_OUT), 0);
    @(posedge CLK); #1;

    // single push from shift unit
    step(4'b0001, 16'hA5A5, 1'b0);
    mid();
    chk("sp_data",  32'(ALU_OUT), 32'hA5A5);
    chk("sp_tag",   32'(Src_Tag), 32'd3);
    chk("sp_valid", 32'(OUT_VALID), 1);
    chk("sp_count", 32'(Fifo_Count), 1);
    @(posedge CLK); #1;
    step(4'b0000, '0, 1'b1);
    mid();
    chk("sp_pop_valid", 32'(OUT_VALID), 0);
    chk("sp_pop_data",  32'(ALU_OUT), 0);
    @(posedge CLK); #1;

    // ordering and pointer wrap
    step(4'b1000, 16'h0001, 1'b0);
    step(4'b0100, 16'h0002, 1'b0);
    step(4'b0010, 16'h0003, 1'b0);
    step(4'b0001, 16'h0004, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, '0, 1'b1);
    step(4'b1000, 16'h0005, 1'b0);
    step(4'b0100, 16'h0006, 1'b0);
    step(4'b0010, 16'h0007, 1'b0);
    step(4'b0001, 16'h0008, 1'b0);
    mid();
    chk("wrap_head", 32'(ALU_OUT), 32'h0005);
    chk("wrap_cnt",  32'(Fifo_Count), 4);
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) step(4'b0000, '0, 1'b1);
    mid();
    chk("wrap_last_data", 32'(ALU_OUT), 32'h0008);
    chk("wrap_last_tag",  32'(Src_Tag), 32'd3);
    @(posedge CLK); #1;
    step(4'b0000, '0, 1'b1);

    // overflow
    step(4'b1000, 16'h0011, 1'b0);
    step(4'b0100, 16'h0012, 1'b0);
    step(4'b0010, 16'h0013, 1'b0);
    step(4'b0001, 16'h0014, 1'b0);
    step(4'b1000, 16'hFFFF, 1'b0);
    mid();
    chk("ovf_pulse", 32'(Overflow_Err), 1);
    chk("ovf_count", 32'(Fifo_Count), 4);
    @(posedge CLK); #1;
    mid();
    chk("ovf_clear", 32'(Overflow_Err), 0);
    @(posedge CLK); #1;

    // full with simultaneous push and pop
    step(4'b0100, 16'h1234, 1'b1);
    mid();
    chk("fpp_count", 32'(Fifo_Count), 4);
    chk("fpp_ovf",   32'(Overflow_Err), 0);
    chk("fpp_head",  32'(ALU_OUT), 32'h0012);
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) step(4'b0000, '0, 1'b1);
    mid();
    chk("fpp_4th", 32'(ALU_OUT), 32'h1234);
    chk("fpp_tag", 32'(Src_Tag), 32'd1);
    @(posedge CLK); #1;
    step(4'b0000, '0, 1'b1);
    chk("no_ffff", 32'(seen_ffff), 0);

    // collision
    step(4'b0010, 16'h0007, 1'b0);
    step(4'b1001, 16'hBEEF, 1'b0);
    mid();
    chk("col_pulse", 32'(Collision_Err), 1);
    chk("col_count", 32'(Fifo_Count), 1);
`ifdef ALU_RESULT_PARITY_EN
    chk("par_0007", 32'(Parity_OUT), 1);
`endif
    @(posedge CLK); #1;
    mid();
    chk("col_clear", 32'(Collision_Err), 0);
    @(posedge CLK); #1;
    step(4'b0000, '0, 1'b1);

    // asynchronous reset mid-stream
    step(4'b1000, 16'h0021, 1'b0);
    step(4'b0100, 16'h0022, 1'b0);
    step(4'b0010, 16'h0023, 1'b0);
    #2 RST = 1'b1;
    #1;
    chk("arst_valid", 32'(OUT_VALID), 0);
    chk("arst_data",  32'(ALU_OUT), 0);
    chk("arst_count", 32'(Fifo_Count), 0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    mid();
    chk("arst_rel_count", 32'(Fifo_Count), 0);
    chk("arst_rel_valid", 32'(OUT_VALID), 0);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
